// File: rtl/id_stage_pkg.sv
// Shared definitions for the instruction decode stage: widths, RV32I opcode
// and funct3 encodings, instruction classes and the pipeline register layout.
package id_stage_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CSR_ADDR_WIDTH = 12;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG     = '0;
  localparam logic                      WRITE_ENABLE = 1'b1;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // SYSTEM funct3 encodings
  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_S,
    CLS_B,
    CLS_U,
    CLS_J,
    CLS_ILL
  } inst_class_e;

  // Payload carried in the ID/EX pipeline register
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     inst;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     csr_rdata;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_we;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
    logic                      csr_we;
    logic                      illegal;
  } ex_payload_t;

  // Map a major opcode onto its immediate/format class
  function automatic inst_class_e classify(input logic [6:0] opcode);
    inst_class_e cls;
    case (opcode)
      OPC_OP:                                        cls = CLS_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:    cls = CLS_I;
      OPC_STORE:                                     cls = CLS_S;
      OPC_BRANCH:                                    cls = CLS_B;
      OPC_LUI, OPC_AUIPC:                            cls = CLS_U;
      OPC_JAL:                                       cls = CLS_J;
      default:                                       cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Combinational RV32I immediate generator: sign-extended immediate for the
// instruction's format class, zero for R-type and unrecognised opcodes.
module imm_gen
  import id_stage_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] imm
);

  inst_class_e cls;

  // Select the immediate layout from the opcode class
  always_comb begin
    cls = classify(inst[6:0]);
    imm = '0;
    case (cls)
      CLS_I:   imm = {{20{inst[31]}}, inst[31:20]};
      CLS_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      CLS_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      CLS_U:   imm = {inst[31:12], 12'b0};
      CLS_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decodes the fetched word, reads register/CSR
// operands, detects load-use hazards and holds the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [DATA_WIDTH-1:0]     if_inst,
  input  logic [DATA_WIDTH-1:0]     if_pc,
  input  logic                      flush,
  output logic [REG_ADDR_WIDTH-1:0] rs1_raddr,
  output logic [REG_ADDR_WIDTH-1:0] rs2_raddr,
  output logic [CSR_ADDR_WIDTH-1:0] csr_raddr,
  input  logic [DATA_WIDTH-1:0]     rs1_rdata,
  input  logic [DATA_WIDTH-1:0]     rs2_rdata,
  input  logic [DATA_WIDTH-1:0]     csr_rdata,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [DATA_WIDTH-1:0]     ex_inst,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [DATA_WIDTH-1:0]     ex_rs1_data,
  output logic [DATA_WIDTH-1:0]     ex_rs2_data,
  output logic [DATA_WIDTH-1:0]     ex_csr_rdata,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic                      ex_rd_we,
  output logic [CSR_ADDR_WIDTH-1:0] ex_csr_waddr,
  output logic                      ex_csr_we,
  output logic                      ex_illegal
);

  localparam ex_payload_t EX_RESET = '{inst: NOP_INST, default: '0};

  ex_payload_t                ex_q, ex_d, dec_payload;
  logic                       ex_valid_q, ex_valid_d;
  logic [DATA_WIDTH-1:0]      if_imm;
  inst_class_e                if_cls;
  logic [2:0]                 if_funct3;
  logic                       if_is_csr;
  logic                       if_rs1_used;
  logic                       if_rs2_used;
  logic                       hold;
  logic                       hazard;

  assign rs1_raddr = if_inst[19:15];
  assign rs2_raddr = if_inst[24:20];
  assign csr_raddr = if_inst[31:20];

  imm_gen u_imm_gen (
    .inst (if_inst),
    .imm  (if_imm)
  );

  // Decode the offered instruction into the payload it would load into ID/EX
  always_comb begin
    if_cls      = classify(if_inst[6:0]);
    if_funct3   = if_inst[14:12];
    if_is_csr   = (if_inst[6:0] == OPC_SYSTEM) && (if_funct3 != F3_PRIV);
    if_rs2_used = (if_cls == CLS_R) || (if_cls == CLS_S) || (if_cls == CLS_B);
    if_rs1_used = if_rs2_used
                || ((if_cls == CLS_I) && (if_inst[6:0] != OPC_SYSTEM))
                || (if_is_csr && !if_funct3[2]);

    dec_payload           = '0;
    dec_payload.pc        = if_pc;
    dec_payload.inst      = if_inst;
    dec_payload.imm       = if_imm;
    dec_payload.rs1_data  = rs1_rdata;
    dec_payload.rs2_data  = rs2_rdata;
    dec_payload.csr_rdata = csr_rdata;
    dec_payload.rd_addr   = if_inst[11:7];
    dec_payload.illegal   = (if_cls == CLS_ILL);
    if (((if_cls == CLS_R) || (if_cls == CLS_I) || (if_cls == CLS_U) || (if_cls == CLS_J))
        && (if_inst[11:7] != ZERO_REG)) begin
      dec_payload.rd_we = WRITE_ENABLE;
    end
    if (if_is_csr) begin
      dec_payload.csr_waddr = if_inst[31:20];
      // Set/clear with a zero source never write the CSR
      if (((if_funct3 == F3_CSRRS) || (if_funct3 == F3_CSRRC) ||
           (if_funct3 == F3_CSRRSI) || (if_funct3 == F3_CSRRCI))
          && (if_inst[19:15] == ZERO_REG)) begin
        dec_payload.csr_we = 1'b0;
      end else begin
        dec_payload.csr_we = WRITE_ENABLE;
      end
    end
  end

  // Stall conditions: downstream back-pressure and load-use dependency
  always_comb begin
    hold   = ex_valid_q && !ex_ready;
    hazard = ex_valid_q
          && (ex_q.inst[6:0] == OPC_LOAD)
          && (ex_q.rd_addr != ZERO_REG)
          && (((ex_q.rd_addr == rs1_raddr) && if_rs1_used)
           || ((ex_q.rd_addr == rs2_raddr) && if_rs2_used));
    if_ready = (!hold && !hazard) || flush;
  end

  // Next pipeline register contents: flush, then hold, then accept, else bubble
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_d.inst  = NOP_INST;
    end else if (hold) begin
      ex_valid_d = ex_valid_q;
      ex_d       = ex_q;
    end else if (if_valid && if_ready) begin
      ex_valid_d = 1'b1;
      ex_d       = dec_payload;
    end else begin
      ex_valid_d = 1'b0;
      ex_d.inst  = NOP_INST;
    end
  end

  // ID/EX pipeline register; reset drops any held instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= EX_RESET;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_q.pc;
  assign ex_inst      = ex_q.inst;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_csr_rdata = ex_q.csr_rdata;
  assign ex_rd_addr   = ex_q.rd_addr;
  assign ex_rd_we     = ex_q.rd_we;
  assign ex_csr_waddr = ex_q.csr_waddr;
  assign ex_csr_we    = ex_q.csr_we;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: per-scenario tasks with a scoreboard of
// expected ID/EX payloads pushed on acceptance and popped on output.
module tb_id_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] csr;
    logic [4:0]  rd;
    logic        rd_we;
    logic [11:0] csr_waddr;
    logic        csr_we;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        flush;
  logic [4:0]  rs1_raddr;
  logic [4:0]  rs2_raddr;
  logic [11:0] csr_raddr;
  logic [31:0] rs1_rdata;
  logic [31:0] rs2_rdata;
  logic [31:0] csr_rdata;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_csr_rdata;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we;
  logic [11:0] ex_csr_waddr;
  logic        ex_csr_we;
  logic        ex_illegal;

  exp_t sb[$];
  int   checks;
  int   failures;

  id_stage #(.NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .flush        (flush),
    .rs1_raddr    (rs1_raddr),
    .rs2_raddr    (rs2_raddr),
    .csr_raddr    (csr_raddr),
    .rs1_rdata    (rs1_rdata),
    .rs2_rdata    (rs2_rdata),
    .csr_rdata    (csr_rdata),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_pc        (ex_pc),
    .ex_inst      (ex_inst),
    .ex_imm       (ex_imm),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs2_data  (ex_rs2_data),
    .ex_csr_rdata (ex_csr_rdata),
    .ex_rd_addr   (ex_rd_addr),
    .ex_rd_we     (ex_rd_we),
    .ex_csr_waddr (ex_csr_waddr),
    .ex_csr_we    (ex_csr_we),
    .ex_illegal   (ex_illegal)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and its operand read data
  task automatic offer(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] c);
    if_valid  = 1'b1;
    if_inst   = inst;
    if_pc     = pc;
    rs1_rdata = r1;
    rs2_rdata = r2;
    csr_rdata = c;
  endtask

  // Build an expected payload record
  function automatic exp_t make_exp(input logic [31:0] pc, input logic [31:0] inst,
                                    input logic [31:0] imm, input logic [31:0] r1,
                                    input logic [31:0] r2, input logic [31:0] c,
                                    input logic [4:0] rd, input logic rd_we,
                                    input logic [11:0] csr_waddr, input logic csr_we,
                                    input logic illegal);
    exp_t e;
    e.pc = pc; e.inst = inst; e.imm = imm; e.rs1 = r1; e.rs2 = r2; e.csr = c;
    e.rd = rd; e.rd_we = rd_we; e.csr_waddr = csr_waddr; e.csr_we = csr_we;
    e.illegal = illegal;
    return e;
  endfunction

  // Snapshot of the DUT's registered payload
  function automatic exp_t observed();
    return make_exp(ex_pc, ex_inst, ex_imm, ex_rs1_data, ex_rs2_data, ex_csr_rdata,
                    ex_rd_addr, ex_rd_we, ex_csr_waddr, ex_csr_we, ex_illegal);
  endfunction

  task automatic test_reset();
    exp_t got;
    exp_t exp;
    rst = 1'b1; if_valid = 1'b0; if_inst = NOP; if_pc = '0; flush = 1'b0;
    ex_ready = 1'b1; rs1_rdata = '0; rs2_rdata = '0; csr_rdata = '0;
    #2;
    got = observed();
    exp = make_exp('0, NOP, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (ex_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_valid got=%b exp=0", ex_valid);
    end
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL reset_payload got=%h exp=%h", got, exp);
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_if_ready got=%b exp=1", if_ready);
    end
  endtask

  task automatic test_addi();
    exp_t got;
    exp_t exp;
    offer(32'h00500093, 32'h100, 32'h11111111, 32'h22222222, 32'h33333333);
    checks++;
    if ({rs1_raddr, rs2_raddr, csr_raddr} !== {5'd0, 5'd5, 12'h005}) begin
      failures++; $display("[TB] FAIL addi_raddr got=%h/%h/%h exp=0/5/005", rs1_raddr, rs2_raddr, csr_raddr);
    end
    checks++;
    if (if_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL addi_if_ready got=%b exp=1", if_ready);
    end
    sb.push_back(make_exp(32'h100, 32'h00500093, 32'd5, 32'h11111111, 32'h22222222,
                          32'h33333333, 5'd1, 1'b1, 12'h000, 1'b0, 1'b0));
    tick();
    if_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL addi_valid got=%b exp=1", ex_valid);
    end
    got = observed();
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL addi_payload got=%h exp=%h", got, exp);
    end
    tick();
    checks++;
    if ({ex_valid, ex_inst} !== {1'b0, NOP}) begin
      failures++; $display("[TB] FAIL addi_drain got=%b/%h exp=0/%h", ex_valid, ex_inst, NOP);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts[5];
    logic [31:0] imms[5];
    logic [4:0]  rds[5];
    logic        wes[5];
    exp_t        got;
    exp_t        exp;
    insts[0] = 32'hFFF00113; imms[0] = 32'hFFFFFFFF; rds[0] = 5'd2;  wes[0] = 1'b1;
    insts[1] = 32'h00112423; imms[1] = 32'h00000008; rds[1] = 5'd8;  wes[1] = 1'b0;
    insts[2] = 32'hFE000CE3; imms[2] = 32'hFFFFFFF8; rds[2] = 5'd25; wes[2] = 1'b0;
    insts[3] = 32'h123453B7; imms[3] = 32'h12345000; rds[3] = 5'd7;  wes[3] = 1'b1;
    insts[4] = 32'h010000EF; imms[4] = 32'h00000010; rds[4] = 5'd1;  wes[4] = 1'b1;
    ex_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(insts[i], 32'h200 + 4 * i, 32'hA0000000 + i, 32'hB0000000 + i, 32'hC0000000 + i);
      checks++;
      if (if_ready !== 1'b1) begin
        failures++; $display("[TB] FAIL b2b_if_ready[%0d] got=%b exp=1", i, if_ready);
      end
      sb.push_back(make_exp(32'h200 + 4 * i, insts[i], imms[i], 32'hA0000000 + i,
                            32'hB0000000 + i, 32'hC0000000 + i, rds[i], wes[i],
                            12'h000, 1'b0, 1'b0));
      tick();
      got = observed();
      exp = sb.pop_front();
      checks++;
      if ({ex_valid, got} !== {1'b1, exp}) begin
        failures++; $display("[TB] FAIL b2b_payload[%0d] got=%b/%h exp=1/%h", i, ex_valid, got, exp);
      end
    end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    exp_t held;
    exp_t got;
    exp_t exp;
    ex_ready = 1'b1;
    offer(32'h00500093, 32'h300, 32'h01010101, 32'h02020202, 32'h03030303);
    sb.push_back(make_exp(32'h300, 32'h00500093, 32'd5, 32'h01010101, 32'h02020202,
                          32'h03030303, 5'd1, 1'b1, 12'h000, 1'b0, 1'b0));
    tick();
    held = sb.pop_front();
    ex_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      offer(32'h002081B3, 32'h304, 32'hDEAD0000 + k, 32'hBEEF0000 + k, 32'hCAFE0000 + k);
      #1;
      checks++;
      if (if_ready !== 1'b0) begin
        failures++; $display("[TB] FAIL hold_if_ready[%0d] got=%b exp=0", k, if_ready);
      end
      tick();
      got = observed();
      checks++;
      if ({ex_valid, got} !== {1'b1, held}) begin
        failures++; $display("[TB] FAIL hold_payload[%0d] got=%b/%h exp=1/%h", k, ex_valid, got, held);
      end
    end
    ex_ready = 1'b1;
    offer(32'h002081B3, 32'h304, 32'h44444444, 32'h55555555, 32'h66666666);
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL hold_release got=%b exp=1", if_ready);
    end
    sb.push_back(make_exp(32'h304, 32'h002081B3, 32'd0, 32'h44444444, 32'h55555555,
                          32'h66666666, 5'd3, 1'b1, 12'h000, 1'b0, 1'b0));
    tick();
    if_valid = 1'b0;
    got = observed();
    exp = sb.pop_front();
    checks++;
    if ({ex_valid, got} !== {1'b1, exp}) begin
      failures++; $display("[TB] FAIL hold_next got=%b/%h exp=1/%h", ex_valid, got, exp);
    end
    tick();
  endtask

  task automatic test_load_use();
    exp_t got;
    exp_t exp;
    ex_ready = 1'b1;
    offer(32'h00012283, 32'h400, 32'h00001000, 32'h0, 32'h0);
    sb.push_back(make_exp(32'h400, 32'h00012283, 32'd0, 32'h00001000, 32'h0, 32'h0,
                          5'd5, 1'b1, 12'h000, 1'b0, 1'b0));
    tick();
    got = observed();
    exp = sb.pop_front();
    checks++;
    if ({ex_valid, got} !== {1'b1, exp}) begin
      failures++; $display("[TB] FAIL lw_payload got=%b/%h exp=1/%h", ex_valid, got, exp);
    end
    // addi x7,x0,5 has rs2 field 5 but does not read rs2: no stall
    offer(32'h00500393, 32'h404, 32'h0, 32'h0, 32'h0);
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL lu_rs2_unused got=%b exp=1", if_ready);
    end
    offer(32'h00128333, 32'h404, 32'h77777777, 32'h88888888, 32'h0);
    #1;
    checks++;
    if (if_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL lu_stall got=%b exp=0", if_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_inst} !== {1'b0, NOP}) begin
      failures++; $display("[TB] FAIL lu_bubble got=%b/%h exp=0/%h", ex_valid, ex_inst, NOP);
    end
    checks++;
    if (if_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL lu_resume got=%b exp=1", if_ready);
    end
    sb.push_back(make_exp(32'h404, 32'h00128333, 32'd0, 32'h77777777, 32'h88888888, 32'h0,
                          5'd6, 1'b1, 12'h000, 1'b0, 1'b0));
    tick();
    if_valid = 1'b0;
    got = observed();
    exp = sb.pop_front();
    checks++;
    if ({ex_valid, got} !== {1'b1, exp}) begin
      failures++; $display("[TB] FAIL lu_add got=%b/%h exp=1/%h", ex_valid, got, exp);
    end
    tick();
  endtask

  task automatic test_csr();
    exp_t got;
    exp_t exp;
    ex_ready = 1'b1;
    offer(32'hB00021F3, 32'h500, 32'h0, 32'h0, 32'h0000ABCD);
    #1;
    checks++;
    if (csr_raddr !== 12'hB00) begin
      failures++; $display("[TB] FAIL csr_raddr got=%h exp=b00", csr_raddr);
    end
    sb.push_back(make_exp(32'h500, 32'hB00021F3, 32'hFFFFFB00, 32'h0, 32'h0, 32'h0000ABCD,
                          5'd3, 1'b1, 12'hB00, 1'b0, 1'b0));
    tick();
    offer(32'h34009073, 32'h504, 32'h0000FFFF, 32'h0, 32'h12340000);
    sb.push_back(make_exp(32'h504, 32'h34009073, 32'h00000340, 32'h0000FFFF, 32'h0,
                          32'h12340000, 5'd0, 1'b0, 12'h340, 1'b1, 1'b0));
    got = observed();
    exp = sb.pop_front();
    checks++;
    if ({ex_valid, got} !== {1'b1, exp}) begin
      failures++; $display("[TB] FAIL csrrs_payload got=%b/%h exp=1/%h", ex_valid, got, exp);
    end
    tick();
    if_valid = 1'b0;
    got = observed();
    exp = sb.pop_front();
    checks++;
    if ({ex_valid, got} !== {1'b1, exp}) begin
      failures++; $display("[TB] FAIL csrrw_payload got=%b/%h exp=1/%h", ex_valid, got, exp);
    end
    tick();
  endtask

  task automatic test_flush();
    ex_ready = 1'b1;
    offer(32'h00500093, 32'h600, 32'h0, 32'h0, 32'h0);
    tick();
    ex_ready = 1'b0;
    flush = 1'b1;
    offer(32'h002081B3, 32'h604, 32'h0, 32'h0, 32'h0);
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL flush_if_ready got=%b exp=1", if_ready);
    end
    tick();
    flush = 1'b0;
    if_valid = 1'b0;
    ex_ready = 1'b1;
    sb.delete();
    checks++;
    if ({ex_valid, ex_inst} !== {1'b0, NOP}) begin
      failures++; $display("[TB] FAIL flush_result got=%b/%h exp=0/%h", ex_valid, ex_inst, NOP);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_dropped got=%b exp=0", ex_valid);
    end
  endtask

  task automatic test_illegal();
    exp_t exp;
    ex_ready = 1'b1;
    offer(32'hFFFFFFFF, 32'h700, 32'h0, 32'h0, 32'h0);
    sb.push_back(make_exp(32'h700, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0,
                          5'd31, 1'b0, 12'h000, 1'b0, 1'b1));
    tick();
    if_valid = 1'b0;
    exp = sb.pop_front();
    checks++;
    if ({ex_valid, ex_illegal, ex_rd_we, ex_csr_we, ex_inst} !==
        {1'b1, exp.illegal, exp.rd_we, exp.csr_we, exp.inst}) begin
      failures++; $display("[TB] FAIL illegal_flags got=%b%b%b%b/%h exp=1100/%h",
                           ex_valid, ex_illegal, ex_rd_we, ex_csr_we, ex_inst, exp.inst);
    end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    ex_ready = 1'b1;
    offer(32'h00500093, 32'h800, 32'h0, 32'h0, 32'h0);
    tick();
    ex_ready = 1'b0;
    if_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ex_valid, ex_inst} !== {1'b0, NOP}) begin
      failures++; $display("[TB] FAIL rst_hold got=%b/%h exp=0/%h", ex_valid, ex_inst, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_hold_ready got=%b exp=1", if_ready);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_no_replay got=%b exp=0", ex_valid);
    end
  endtask

  // Scenario sequence
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_hold();
    test_load_use();
    test_csr();
    test_flush();
    test_illegal();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
